// File: rtl/am_i_sink_top.sv
// Sink/forwarding decision engine over a byte-addressed scratch memory shared with a host port.
// Build macro AM_I_FORWARDING_EN enables the forwarding stage (FWD); without it WRITE goes straight to DONE.
module am_i_sink_top #(
   parameter int MEM_DEPTH  = 1024,
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [15:0]           my_node_id,
   input  logic [15:0]           destination_id,
   input  logic                  host_we,
   input  logic [15:0]           host_addr,
   input  logic [WORD_WIDTH-1:0] host_wdata,
   output logic [WORD_WIDTH-1:0] host_rdata,
   output logic                  for_aggregation,
   output logic                  done_sink,
   output logic                  iam_forwarding,
   output logic                  done_forwarding,
   output logic [2:0]            fsm_state
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [AW-1:0] SINK_HI = AW'(0 % MEM_DEPTH);
   localparam logic [AW-1:0] SINK_LO = AW'(1 % MEM_DEPTH);
   localparam logic [AW-1:0] AGG_HI  = AW'(2 % MEM_DEPTH);
   localparam logic [AW-1:0] AGG_LO  = AW'(3 % MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, FWD, DONE} state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem [MEM_DEPTH];
   logic [AW-1:0]   host_idx0, host_idx1;
   logic [15:0]     rd_word;
   logic            sink_q;
   logic            done_sink_q, agg_q;

   assign host_idx0  = AW'(32'(host_addr) % MEM_DEPTH);
   assign host_idx1  = AW'((32'(host_addr) + 32'd1) % MEM_DEPTH);
   assign host_rdata = {mem[host_idx0], mem[host_idx1]};
   assign fsm_state  = state_q;

   // Engine write is issued after the host write so it wins on a shared byte; reset suppresses it.
   always_ff @(posedge clock) begin
      if (host_we) begin
         mem[host_idx0] <= host_wdata[15:8];
         mem[host_idx1] <= host_wdata[7:0];
      end
      if (state_q == WRITE && !nrst) begin
         mem[AGG_HI] <= 8'h00;
         mem[AGG_LO] <= {7'b0, sink_q};
      end
   end

   always_ff @(posedge clock) begin
      if (state_q == READ) rd_word <= {mem[SINK_HI], mem[SINK_LO]};
   end

   always_ff @(posedge clock) begin
      if (nrst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // start is a level, not a handshake: it is only looked at in IDLE and ignored everywhere else.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = READ;
         READ:  state_d = EVAL;
         EVAL:  state_d = WRITE;
`ifdef AM_I_FORWARDING_EN
         WRITE: state_d = FWD;
`else
         WRITE: state_d = DONE;
`endif
         FWD:   state_d = DONE;
         DONE:  state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (nrst) begin
         sink_q      <= 1'b0;
         done_sink_q <= 1'b0;
         agg_q       <= 1'b0;
      end else begin
         if (state_q == EVAL) sink_q <= (rd_word != 16'h0000);
         if (state_q == WRITE) begin
            done_sink_q <= 1'b1;
            agg_q       <= sink_q;
         end
      end
   end

   assign done_sink       = done_sink_q;
   assign for_aggregation = agg_q;

`ifdef AM_I_FORWARDING_EN
   logic fwd_q, done_fwd_q;

   // Node IDs are only looked at while in FWD.
   always_ff @(posedge clock) begin
      if (nrst) begin
         fwd_q      <= 1'b0;
         done_fwd_q <= 1'b0;
      end else if (state_q == FWD) begin
         fwd_q      <= (my_node_id == destination_id);
         done_fwd_q <= 1'b1;
      end
   end

   assign iam_forwarding  = fwd_q;
   assign done_forwarding = done_fwd_q;
`else
   logic unused_ids;
   assign unused_ids      = ^{my_node_id, destination_id};
   assign iam_forwarding  = 1'b0;
   assign done_forwarding = 1'b0;
`endif

endmodule

// File: tb/tb_am_i_sink_top.sv
// Directed bench for am_i_sink_top: vector table of sink/forward runs plus reset, collision and wrap sequences.
module tb_am_i_sink_top;

`ifdef AM_I_FORWARDING_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        nrst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] my_node_id = '0;
   logic [15:0] destination_id = '0;
   logic        host_we = 1'b0;
   logic [15:0] host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic [15:0] host_rdata;
   logic        for_aggregation, done_sink, iam_forwarding, done_forwarding;
   logic [2:0]  fsm_state;

   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q[$];

   am_i_sink_top dut (
      .clock(clock), .nrst(nrst), .start(start),
      .my_node_id(my_node_id), .destination_id(destination_id),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .for_aggregation(for_aggregation),
      .done_sink(done_sink), .iam_forwarding(iam_forwarding),
      .done_forwarding(done_forwarding), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] word0;
      logic [15:0] my_id;
      logic [15:0] dst_id;
      logic [15:0] exp_flag;
      logic        exp_agg;
      logic        exp_fwd;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      nrst  = 1'b1;
      start = 1'b0;
      @(negedge clock);
      nrst  = 1'b0;
   endtask

   task automatic host_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clock);
      host_we    = 1'b1;
      host_addr  = a;
      host_wdata = d;
      @(negedge clock);
      host_we    = 1'b0;
   endtask

   task automatic host_read(input logic [15:0] a, output logic [15:0] d);
      host_addr = a;
      #1;
      d = host_rdata;
   endtask

   // c = 0 is the first negedge after the edge that samples start.
   task automatic wait_done(output int t_sink, output int t_fwd);
      t_sink = -1;
      t_fwd  = -1;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clock);
         if (done_sink === 1'b1 && t_sink < 0) t_sink = c;
         if (done_forwarding === 1'b1 && t_fwd < 0) t_fwd = c;
      end
   endtask

   initial begin
      logic [15:0] rd;
      int ts, tf;

      vecs[0] = '{16'h0001, 16'd3, 16'd3, 16'h0001, 1'b1, 1'b1};
      vecs[1] = '{16'h0000, 16'd3, 16'd5, 16'h0000, 1'b0, 1'b0};
      vecs[2] = '{16'h8000, 16'd7, 16'd7, 16'h0001, 1'b1, 1'b1};
      vecs[3] = '{16'h0100, 16'd9, 16'd0, 16'h0001, 1'b1, 1'b0};

      repeat (2) @(negedge clock);
      nrst = 1'b0;
      check("reset_state", int'(fsm_state), 0);
      check("reset_done_sink", int'(done_sink), 0);
      check("reset_for_aggregation", int'(for_aggregation), 0);
      check("reset_iam_forwarding", int'(iam_forwarding), 0);
      check("reset_done_forwarding", int'(done_forwarding), 0);

      for (int i = 0; i < 4; i++) begin
         do_reset();
         host_write(16'h0000, vecs[i].word0);
         host_write(16'h0002, 16'h5A5A);
         my_node_id     = vecs[i].my_id;
         destination_id = vecs[i].dst_id;
         host_read(16'h0000, rd);
         check($sformatf("v%0d_word0_readback", i), int'(rd), int'(vecs[i].word0));
         exp_q.push_back(vecs[i].exp_flag);
         @(negedge clock);
         start = 1'b1;
         wait_done(ts, tf);
         start = 1'b0;
         check($sformatf("v%0d_done_sink_latency", i), ts, 3);
         check($sformatf("v%0d_done_fwd_latency", i), tf, FWD_EN ? 4 : -1);
         check($sformatf("v%0d_for_aggregation", i), int'(for_aggregation), int'(vecs[i].exp_agg));
         check($sformatf("v%0d_iam_forwarding", i), int'(iam_forwarding), FWD_EN ? int'(vecs[i].exp_fwd) : 0);
         check($sformatf("v%0d_done_forwarding", i), int'(done_forwarding), FWD_EN ? 1 : 0);
         check($sformatf("v%0d_state_done", i), int'(fsm_state), 5);
         host_read(16'h0002, rd);
         check($sformatf("v%0d_flag_word", i), int'(rd), int'(exp_q.pop_front()));
      end

      // DONE ignores start and the IDs stop being sampled.
      my_node_id     = 16'd1;
      destination_id = 16'd1;
      start          = 1'b1;
      repeat (4) @(negedge clock);
      start = 1'b0;
      check("done_hold_state", int'(fsm_state), 5);
      check("done_hold_iam_forwarding", int'(iam_forwarding), 0);
      check("done_hold_done_sink", int'(done_sink), 1);

      // Reset landing in WRITE: flag word untouched, outputs cleared, held start restarts the run.
      do_reset();
      host_write(16'h0000, 16'h0001);
      host_write(16'h0002, 16'h1234);
      my_node_id     = 16'd3;
      destination_id = 16'd3;
      @(negedge clock);
      start = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_write_in_write", int'(fsm_state), 3);
      nrst = 1'b1;
      @(negedge clock);
      nrst = 1'b0;
      check("rst_write_state_idle", int'(fsm_state), 0);
      check("rst_write_done_sink", int'(done_sink), 0);
      check("rst_write_for_aggregation", int'(for_aggregation), 0);
      host_read(16'h0002, rd);
      check("rst_write_flag_kept", int'(rd), 16'h1234);
      wait_done(ts, tf);
      start = 1'b0;
      check("rst_write_rerun_latency", ts, 3);
      check("rst_write_rerun_fwd_latency", tf, FWD_EN ? 4 : -1);
      host_read(16'h0002, rd);
      check("rst_write_rerun_flag", int'(rd), 16'h0001);

      // Host and engine writing the flag word in the same cycle: engine wins.
      do_reset();
      host_write(16'h0000, 16'h0000);
      @(negedge clock);
      start = 1'b1;
      repeat (3) @(negedge clock);
      check("collide_in_write", int'(fsm_state), 3);
      host_we    = 1'b1;
      host_addr  = 16'h0002;
      host_wdata = 16'hFFFF;
      @(negedge clock);
      host_we = 1'b0;
      start   = 1'b0;
      host_read(16'h0002, rd);
      check("collide_engine_wins", int'(rd), 16'h0000);
      check("collide_done_sink", int'(done_sink), 1);

      // Byte-address wrap at the top of memory, and persistence across reset.
      host_write(16'h0000, 16'h1122);
      host_write(16'h03FF, 16'hABCD);
      host_read(16'h03FF, rd);
      check("wrap_word_3ff", int'(rd), 16'hABCD);
      host_read(16'h0000, rd);
      check("wrap_word_000", int'(rd), 16'hCD22);
      host_read(16'h0400, rd);
      check("wrap_alias_400", int'(rd), 16'hCD22);
      do_reset();
      host_read(16'h03FF, rd);
      check("wrap_persist_after_reset", int'(rd), 16'hABCD);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
